// File: rtl/ex_divider_pkg.sv
// ex_divider_pkg: divider state encodings, divide-by-zero result, ALU op codes and a magnitude helper
package ex_divider_pkg;
   localparam int DIV_W = 32;
   localparam int DIV_CNT_W = 6;
   localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = '1;
   localparam logic [7:0] ALU_DIV = 8'b0001_1010;
   localparam logic [7:0] ALU_DIVU = 8'b0001_1011;
   typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_CALC = 2'd1, DIV_DONE = 2'd2} div_state_e;
   function automatic logic [DIV_W-1:0] div_mag(input logic [DIV_W-1:0] v, input logic s);
      return s & v[DIV_W-1] ? -v : v;
   endfunction
endpackage

// File: rtl/ex_divider_if.sv
// ex_divider_if: EX-stage divider bus; master drives flush/start/sign/opr1/opr2/hold, slave returns stall_req/done/quot/rem
interface ex_divider_if
   import ex_divider_pkg::*;
#(
   parameter int WIDTH = DIV_W
);
   logic flush;
   logic start;
   logic sign;
   logic hold;
   logic [WIDTH-1:0] opr1;
   logic [WIDTH-1:0] opr2;
   logic stall_req;
   logic done;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   modport master (output flush, start, sign, hold, opr1, opr2, input stall_req, done, quot, rem);
   modport slave (input flush, start, sign, hold, opr1, opr2, output stall_req, done, quot, rem);
endinterface

// File: rtl/ex_divider.sv
// ex_divider: radix-2 restoring DIV/DIVU, one quotient bit per cycle; ports clk, rst (async, active-high), bus (ex_divider_if.slave)
module ex_divider
   import ex_divider_pkg::*;
#(
   parameter int WIDTH = DIV_W,
   parameter int CNT_W = DIV_CNT_W
) (
   input logic clk,
   input logic rst,
   ex_divider_if.slave bus
);
   div_state_e r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_dvd, r_dvs, r_prem, r_quot, r_rem;
   logic r_qneg, r_rneg;
   logic [WIDTH:0] w_sh, w_diff;
   logic w_borrow, w_last;
   logic [WIDTH-1:0] w_q, w_r;
   assign w_sh = {r_prem, r_dvd[WIDTH-1]};
   assign w_diff = w_sh - {1'b0, r_dvs};
   assign w_borrow = w_diff[WIDTH];
   assign w_q = {r_dvd[WIDTH-2:0], ~w_borrow};
   assign w_r = w_borrow ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
   assign w_last = r_cnt == CNT_W'(WIDTH - 1);
   assign bus.done = r_state == DIV_DONE;
   assign bus.stall_req = bus.start & (r_state != DIV_DONE);
   assign bus.quot = r_quot;
   assign bus.rem = r_rem;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= DIV_IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         DIV_IDLE: w_next = bus.start ? (bus.opr2 == '0 ? DIV_DONE : DIV_CALC) : DIV_IDLE;
         DIV_CALC: w_next = w_last ? DIV_DONE : DIV_CALC;
         DIV_DONE: w_next = bus.hold ? DIV_DONE : DIV_IDLE;
         default: w_next = DIV_IDLE;
      endcase
      if (bus.flush) w_next = DIV_IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cnt <= '0;
         r_dvd <= '0;
         r_dvs <= '0;
         r_prem <= '0;
         r_quot <= '0;
         r_rem <= '0;
         r_qneg <= 1'b0;
         r_rneg <= 1'b0;
      end else if (!bus.flush) begin
         if (r_state == DIV_IDLE && bus.start) begin
            r_dvd <= div_mag(bus.opr1, bus.sign);
            r_dvs <= div_mag(bus.opr2, bus.sign);
            r_prem <= '0;
            r_cnt <= '0;
            r_qneg <= bus.sign & (bus.opr1[WIDTH-1] ^ bus.opr2[WIDTH-1]);
            r_rneg <= bus.sign & bus.opr1[WIDTH-1];
            if (bus.opr2 == '0) begin
               r_quot <= DIV_ZERO_QUOT;
               r_rem <= bus.opr1;
            end
         end else if (r_state == DIV_CALC) begin
            r_dvd <= w_q;
            r_prem <= w_r;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_quot <= r_qneg ? -w_q : w_q;
               r_rem <= r_rneg ? -w_r : w_r;
            end
         end
      end
endmodule

// File: tb/tb_ex_divider.sv
// tb_ex_divider: directed and random DIV/DIVU checks of ex_divider against an arithmetic reference model
module tb_ex_divider;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;
   ex_divider_if bus ();
   ex_divider dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int hc, input logic b2b);
      logic [31:0] eq, er;
      longint sa, sb, q64, r64;
      int lat, stl, exp_lat;
      if (b == 0) begin
         eq = 32'hFFFF_FFFF;
         er = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q64 = sa / sb;
         r64 = sa % sb;
         eq = q64[31:0];
         er = r64[31:0];
      end else begin
         eq = a / b;
         er = a % b;
      end
      exp_lat = (b == 0) ? 1 : 33;
      bus.start = 1'b1;
      bus.sign = s;
      bus.opr1 = a;
      bus.opr2 = b;
      bus.hold = hc > 0;
      @(negedge clk);
      chk("done_c0", {31'd0, bus.done}, 32'd0);
      lat = 0;
      stl = bus.stall_req ? 1 : 0;
      while (!bus.done && lat < 40) begin
         @(posedge clk);
         #1;
         bus.opr1 = $urandom;
         bus.opr2 = $urandom;
         lat++;
         @(negedge clk);
         if (!bus.done && bus.stall_req) stl++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("stall_cycles", 32'(stl), 32'(exp_lat));
      chk("stall_in_done", {31'd0, bus.stall_req}, 32'd0);
      chk("quot", bus.quot, eq);
      chk("rem", bus.rem, er);
      for (int i = 0; i < hc; i++) begin
         @(posedge clk);
         #1;
         if (i == hc - 1) bus.hold = 1'b0;
         @(negedge clk);
         chk("hold_done", {31'd0, bus.done}, 32'd1);
         chk("hold_quot", bus.quot, eq);
         chk("hold_rem", bus.rem, er);
      end
      last_q = eq;
      last_r = er;
      @(posedge clk);
      #1;
      bus.start = b2b;
      if (!b2b) begin
         @(negedge clk);
         chk("idle_done", {31'd0, bus.done}, 32'd0);
         chk("idle_stall", {31'd0, bus.stall_req}, 32'd0);
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      logic seen;
      logic s;
      logic [31:0] a, b;
      bus.flush = 1'b0;
      bus.start = 1'b0;
      bus.sign = 1'b0;
      bus.hold = 1'b0;
      bus.opr1 = '0;
      bus.opr2 = '0;
      #2;
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
      chk("rst_quot", bus.quot, 32'd0);
      chk("rst_rem", bus.rem, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 0, 1'b0);
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      do_div(1'b0, 32'h1234_5678, 32'd0, 0, 1'b0);
      do_div(1'b1, 32'hFFFF_FF00, 32'd0, 0, 1'b0);
      bus.start = 1'b1;
      bus.sign = 1'b0;
      bus.opr1 = 32'd1000;
      bus.opr2 = 32'd3;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      chk("flush_done", {31'd0, bus.done}, 32'd0);
      chk("flush_stall", {31'd0, bus.stall_req}, 32'd0);
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         seen |= bus.done;
      end
      chk("flush_never_done", {31'd0, seen}, 32'd0);
      chk("flush_quot_held", bus.quot, last_q);
      chk("flush_rem_held", bus.rem, last_r);
      @(posedge clk);
      #1;
      do_div(1'b0, 32'd9, 32'd3, 0, 1'b0);
      do_div(1'b0, 32'd50, 32'd5, 5, 1'b1);
      do_div(1'b0, 32'd7, 32'd7, 0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         s = 1'($urandom % 2);
         a = $urandom;
         b = ($urandom % 4 == 0) ? 32'($urandom % 16) : $urandom;
         if ($urandom % 3 == 0) b = b >> ($urandom % 32);
         do_div(s, a, b, int'($urandom % 3), (i < 9) ? 1'($urandom % 2) : 1'b0);
      end
      bus.start = 1'b1;
      bus.sign = 1'b1;
      bus.opr1 = 32'hFFFF_F000;
      bus.opr2 = 32'd7;
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      chk("midrst_quot", bus.quot, 32'd0);
      chk("midrst_rem", bus.rem, 32'd0);
      chk("midrst_stall_start", {31'd0, bus.stall_req}, 32'd1);
      bus.start = 1'b0;
      #1;
      chk("midrst_stall", {31'd0, bus.stall_req}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", {31'd0, bus.done}, 32'd0);
      @(posedge clk);
      #1;
      do_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
